// File: rtl/ssc_controller.sv
// ssc_controller: FSM sequencer for the in-place selection-sort datapath.
// Owns the outer (Cnt1) and inner (Cnt2) indices and registers every datapath strobe.
module ssc_controller #(
  parameter int N    = 16,
  parameter int BASE = 0
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  output logic       Busy,
  output logic       Done,
  output logic       Mem_Write,
  output logic [7:0] Cnt1_Out,
  output logic [7:0] Cnt2_Out,
  output logic [1:0] Sel_AMux,
  output logic       Sel_DMux,
  output logic       Sel_Mux,
  output logic       Load_Min,
  output logic       Load_Temp
);

  if (N < 2 || N > 256) begin : g_bad_n
    $error("ssc_controller: N=%0d outside legal range 2..256", N);
  end
  if (BASE < 0 || BASE + N - 1 > 255) begin : g_bad_base
    $error("ssc_controller: BASE=%0d with N=%0d exceeds address 255", BASE, N);
  end

  localparam logic [7:0] FIRST   = 8'(BASE);
  localparam logic [7:0] LAST    = 8'(BASE + N - 1);
  localparam logic [7:0] LAST_M1 = 8'(BASE + N - 2);

  localparam logic [1:0] AMUX_CNT1 = 2'b00;
  localparam logic [1:0] AMUX_CNT2 = 2'b01;
  localparam logic [1:0] AMUX_MIN  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_SCAN,
    S_SWAP1,
    S_SWAP2,
    S_DONE
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       mem_write;
    logic [1:0] sel_amux;
    logic       sel_dmux;
    logic       sel_mux;
    logic       load_min;
    logic       load_temp;
  } ctl_t;

  state_t     r_state;
  ctl_t       r_ctl;
  logic [7:0] r_cnt1;
  logic [7:0] r_cnt2;

  // Moore decode; registered together with the state so outputs are glitch-free.
  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_LOAD_I: begin
        c.busy      = 1'b1;
        c.sel_amux  = AMUX_CNT1;
        c.sel_mux   = 1'b0;
        c.load_min  = 1'b1;
        c.load_temp = 1'b1;
      end
      S_SCAN: begin
        c.busy     = 1'b1;
        c.sel_amux = AMUX_CNT2;
        c.sel_mux  = 1'b1;
      end
      S_SWAP1: begin
        c.busy      = 1'b1;
        c.sel_amux  = AMUX_CNT1;
        c.sel_dmux  = 1'b0;
        c.mem_write = 1'b1;
      end
      S_SWAP2: begin
        c.busy      = 1'b1;
        c.sel_amux  = AMUX_MIN;
        c.sel_dmux  = 1'b1;
        c.mem_write = 1'b1;
      end
      S_DONE: begin
        c.busy = 1'b1;
        c.done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_ctl   <= '0;
      r_cnt1  <= '0;
      r_cnt2  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_cnt1  <= FIRST;
            r_state <= S_LOAD_I;
            r_ctl   <= decode(S_LOAD_I);
          end
        end
        S_LOAD_I: begin
          r_cnt2  <= r_cnt1 + 8'd1;
          r_state <= S_SCAN;
          r_ctl   <= decode(S_SCAN);
        end
        S_SCAN: begin
          if (r_cnt2 == LAST) begin
            r_state <= S_SWAP1;
            r_ctl   <= decode(S_SWAP1);
          end else begin
            r_cnt2 <= r_cnt2 + 8'd1;
          end
        end
        S_SWAP1: begin
          r_state <= S_SWAP2;
          r_ctl   <= decode(S_SWAP2);
        end
        // The swap is unconditional, so a self-swap simply rewrites mem[i] twice.
        S_SWAP2: begin
          if (r_cnt1 == LAST_M1) begin
            r_state <= S_DONE;
            r_ctl   <= decode(S_DONE);
          end else begin
            r_cnt1  <= r_cnt1 + 8'd1;
            r_state <= S_LOAD_I;
            r_ctl   <= decode(S_LOAD_I);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ctl   <= decode(S_IDLE);
        end
        default: begin
          r_state <= S_IDLE;
          r_ctl   <= '0;
        end
      endcase
    end
  end

  assign Busy      = r_ctl.busy;
  assign Done      = r_ctl.done;
  assign Mem_Write = r_ctl.mem_write;
  assign Sel_AMux  = r_ctl.sel_amux;
  assign Sel_DMux  = r_ctl.sel_dmux;
  assign Sel_Mux   = r_ctl.sel_mux;
  assign Load_Min  = r_ctl.load_min;
  assign Load_Temp = r_ctl.load_temp;
  assign Cnt1_Out  = r_cnt1;
  assign Cnt2_Out  = r_cnt2;

endmodule

// File: tb/tb_ssc_controller.sv
// tb_ssc_controller: two controllers (N=4/BASE=0, N=16/BASE=8) each driving a behavioural
// datapath and memory; final contents and timing are compared against a plain sort model.
module tb_ssc_controller;
  localparam int W = 16;
  localparam int NN [2] = '{4, 16};
  localparam int BB [2] = '{0, 8};

  typedef logic [W-1:0] wq_t [$];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       [2];
  logic       start     [2];
  logic       busy      [2];
  logic       done      [2];
  logic       mem_write [2];
  logic [7:0] cnt1      [2];
  logic [7:0] cnt2      [2];
  logic [1:0] sel_amux  [2];
  logic       sel_dmux  [2];
  logic       sel_mux   [2];
  logic       load_min  [2];
  logic       load_temp [2];

  ssc_controller #(.N(4), .BASE(0)) u_dut0 (
    .Clk(clk), .Rst(rst[0]), .Start(start[0]), .Busy(busy[0]), .Done(done[0]),
    .Mem_Write(mem_write[0]), .Cnt1_Out(cnt1[0]), .Cnt2_Out(cnt2[0]),
    .Sel_AMux(sel_amux[0]), .Sel_DMux(sel_dmux[0]), .Sel_Mux(sel_mux[0]),
    .Load_Min(load_min[0]), .Load_Temp(load_temp[0])
  );

  ssc_controller #(.N(16), .BASE(8)) u_dut1 (
    .Clk(clk), .Rst(rst[1]), .Start(start[1]), .Busy(busy[1]), .Done(done[1]),
    .Mem_Write(mem_write[1]), .Cnt1_Out(cnt1[1]), .Cnt2_Out(cnt2[1]),
    .Sel_AMux(sel_amux[1]), .Sel_DMux(sel_dmux[1]), .Sel_Mux(sel_mux[1]),
    .Load_Min(load_min[1]), .Load_Temp(load_temp[1])
  );

  // ---------------- datapath + memory environment ----------------
  logic [W-1:0] mem      [2][256];
  logic [W-1:0] init_buf [2][256];
  logic         init_req [2];
  logic [W-1:0] min_reg  [2];
  logic [W-1:0] temp_reg [2];
  logic [W-1:0] rd_data  [2];
  logic [7:0]   min_addr [2];
  logic [7:0]   rd_addr  [2];

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      rd_addr[g] = cnt1[g];
      case (sel_amux[g])
        2'b01:   rd_addr[g] = cnt2[g];
        2'b10:   rd_addr[g] = min_addr[g];
        default: ;
      endcase
      rd_data[g] = mem[g][rd_addr[g]];
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (init_req[g]) begin
        for (int a = 0; a < 256; a++) mem[g][a] <= init_buf[g][a];
      end else if (mem_write[g]) begin
        mem[g][rd_addr[g]] <= sel_dmux[g] ? temp_reg[g] : min_reg[g];
      end
      if (load_min[g] || (rd_data[g] < min_reg[g])) begin
        min_reg[g]  <= rd_data[g];
        min_addr[g] <= sel_mux[g] ? cnt2[g] : cnt1[g];
      end
      if (load_temp[g]) temp_reg[g] <= rd_data[g];
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_lat_q[$];
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outvec(input int g);
    return {7'd0, busy[g], done[g], mem_write[g], cnt1[g], cnt2[g], sel_amux[g],
            sel_dmux[g], sel_mux[g], load_min[g], load_temp[g]};
  endfunction

  int   busy_cnt  [2] = '{0, 0};
  int   wr_cnt    [2] = '{0, 0};
  int   wr_total  [2] = '{0, 0};
  int   done_cnt  [2] = '{0, 0};
  logic done_prev [2] = '{1'b0, 1'b0};

  // Monitor: walks every cycle of each instance; pops expectations when Done appears.
  always @(negedge clk) begin : monitor
    int bc, wc;
    int lat;
    for (int g = 0; g < 2; g++) begin
      bc = busy[g] ? busy_cnt[g] + 1 : 0;
      wc = busy[g] ? wr_cnt[g] : 0;
      if (done_prev[g]) check("done_pulse_width", {31'd0, done[g]}, 32'd0);
      if (mem_write[g]) begin
        check("wr_addr_in_range",
              {31'd0, (int'(rd_addr[g]) >= BB[g]) && (int'(rd_addr[g]) <= BB[g] + NN[g] - 1)},
              32'd1);
        check("swap_selects", {29'd0, sel_amux[g], sel_dmux[g]},
              (wc % 2 == 0) ? 32'd0 : 32'd5);
        wc++;
        wr_total[g] <= wr_total[g] + 1;
      end
      if (done[g]) begin
        done_cnt[g] <= done_cnt[g] + 1;
        if (exp_lat_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          lat = exp_lat_q.pop_front();
          check("done_latency", bc, lat);
          check("write_cycles", wc, 2 * (NN[g] - 1));
          for (int k = 0; k < NN[g]; k++)
            check("sorted_word", {16'd0, mem[g][BB[g] + k]}, {16'd0, exp_q.pop_front()});
        end
      end
      busy_cnt[g]  <= bc;
      wr_cnt[g]    <= wc;
      done_prev[g] <= done[g];
    end
  end

  // ---------------- reference model ----------------
  task automatic push_expect(input int d, input wq_t v);
    wq_t s;
    logic [W-1:0] t;
    int n;
    s = v;
    for (int a = 1; a < s.size(); a++)
      for (int b = a; b > 0 && s[b-1] > s[b]; b--) begin
        t = s[b]; s[b] = s[b-1]; s[b-1] = t;
      end
    for (int k = 0; k < s.size(); k++) exp_q.push_back(s[k]);
    n = NN[d];
    exp_lat_q.push_back(n * (n - 1) / 2 + 3 * (n - 1) + 1);
  endtask

  // ---------------- drivers ----------------
  task automatic prep(input int d, input wq_t v);
    for (int a = 0; a < 256; a++) init_buf[d][a] = W'($urandom);
    for (int k = 0; k < NN[d]; k++) init_buf[d][BB[d] + k] = v[k];
    init_req[d] = 1'b1;
    @(negedge clk);
    init_req[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic run_sort(input int d, input wq_t v, input bit poke);
    int n0;
    prep(d, v);
    push_expect(d, v);
    n0 = done_cnt[d];
    pulse_start(d);                 // now in cycle 1
    if (poke) begin
      repeat (2) @(negedge clk);    // cycle 3
      pulse_start(d);
      repeat (6) @(negedge clk);    // cycle 10
      pulse_start(d);
    end
    for (int t = 0; t < 2000 && done_cnt[d] == n0; t++) @(negedge clk);
    check("done_seen", {31'd0, done_cnt[d] != n0}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic rand_words(input int d, input bit narrow, output wq_t v);
    v.delete();
    for (int k = 0; k < NN[d]; k++)
      v.push_back(narrow ? W'($urandom_range(0, 3)) : W'($urandom));
  endtask

  task automatic reset_mid_sort();
    wq_t v, part;
    int mi, w0;
    rand_words(0, 1'b0, v);
    prep(0, v);
    pulse_start(0);                 // cycle 1
    repeat (7) @(negedge clk);      // cycle 8: scanning for outer index 1
    check("busy_before_reset", {31'd0, busy[0]}, 32'd1);
    #1 rst[0] = 1'b1;
    #1 check("async_reset_outputs", outvec(0), 32'd0);
    w0 = wr_total[0];
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("no_write_after_reset", wr_total[0] - w0, 32'd0);
    check("idle_after_reset", outvec(0), 32'd0);
    part = v;
    mi = 0;
    for (int k = 1; k < NN[0]; k++) if (v[k] < v[mi]) mi = k;
    part[mi] = v[0];
    part[0]  = v[mi];
    for (int k = 0; k < NN[0]; k++) check("partial_word", {16'd0, mem[0][k]}, {16'd0, part[k]});
    run_sort(0, part, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    wq_t v;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1;
      start[g] = 1'b0;
      init_req[g] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) check("reset_outputs", outvec(g), 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) check("idle_outputs", outvec(g), 32'd0);

    v = {}; v.push_back(16'd3); v.push_back(16'd1); v.push_back(16'd2); v.push_back(16'd0);
    run_sort(0, v, 1'b0);
    v = {}; v.push_back(16'd1); v.push_back(16'd2); v.push_back(16'd3); v.push_back(16'd4);
    run_sort(0, v, 1'b0);
    v = {}; for (int k = 0; k < 4; k++) v.push_back(16'd5);
    run_sort(0, v, 1'b0);
    v = {}; v.push_back(16'hFFFF); v.push_back(16'h0000); v.push_back(16'hFFFF); v.push_back(16'h0000);
    run_sort(0, v, 1'b0);
    v = {}; for (int k = 0; k < 16; k++) v.push_back(W'(15 - k));
    run_sort(1, v, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rand_words(0, r[0], v);
      run_sort(0, v, 1'b0);
    end
    for (int r = 0; r < 3; r++) begin
      rand_words(1, r[0], v);
      run_sort(1, v, 1'b0);
    end

    rand_words(1, 1'b0, v);
    run_sort(1, v, 1'b1);
    rand_words(0, 1'b1, v);
    run_sort(0, v, 1'b1);

    reset_mid_sort();

    check("queues_drained", exp_q.size() + exp_lat_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ssc_controller.md
Name: ssc_controller

Overview:
- FSM sequencer for the selection-sort datapath (ssc_datapath).
- On Start, sorts N 16-bit words in data memory (addresses BASE..BASE+N-1) into ascending order, in place.
- Owns both address counters. Drives the address/data mux selects, min/temp load strobes and memory write enable. Pulses Done on completion.
- Data memory has combinational read and synchronous write (write on Clk rising edge when Mem_Write=1).

Parameters:
- N, 16, number of words to sort. Legal range 2..256; elaboration error outside this range.
- BASE, 0, first memory address. BASE+N-1 must be ≤ 255; elaboration error otherwise.

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous active-high reset
- Start  in  1  begin sort; sampled only in IDLE
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse in DONE state
- Mem_Write  out  1  data memory write enable
- Cnt1_Out  out  8  outer index i (to datapath)
- Cnt2_Out  out  8  inner index j (to datapath)
- Sel_AMux  out  2  address select: 00=Cnt1, 01=Cnt2, 10=Min_Addr, 11 never driven
- Sel_DMux  out  1  write data select: 0=Min_Reg, 1=Temp_Reg
- Sel_Mux  out  1  min-address source: 0=Cnt1, 1=Cnt2
- Load_Min  out  1  force load of min value/min address
- Load_Temp  out  1  load temp register from Read_Data

Behaviour:
- Reset values: state=IDLE; Cnt1=Cnt2=0; Busy=Done=Mem_Write=Load_Min=Load_Temp=0; Sel_AMux=00; Sel_DMux=0; Sel_Mux=0.
- Control outputs are Moore decodes of state. Counters are registers. Any control output not listed for a state is 0.
- LAST = BASE+N-1.
- Datapath contract: the datapath comparator loads min automatically whenever Read_Data < Min_Reg. The controller keeps Sel_Mux=1 during SCAN so an auto-load captures Cnt2 as the min address.
- IDLE: Start=1 → Cnt1<=BASE, go LOAD_I. Otherwise stay.
- LOAD_I: Sel_AMux=00, Sel_Mux=0, Load_Min=1, Load_Temp=1. Cnt2<=Cnt1+1. Go SCAN.
- SCAN: Sel_AMux=01, Sel_Mux=1.
  - Cnt2==LAST → go SWAP1.
  - Otherwise Cnt2<=Cnt2+1, stay in SCAN.
- SWAP1: Sel_AMux=00, Sel_DMux=0, Mem_Write=1. Writes min to mem[i]. Go SWAP2.
- SWAP2: Sel_AMux=10, Sel_DMux=1, Mem_Write=1. Writes the original mem[i] to mem[min_addr].
  - Cnt1==LAST-1 → go DONE.
  - Otherwise Cnt1<=Cnt1+1, go LOAD_I.
- DONE: Done=1, Busy=1. Go IDLE.
- Self-swap: when min_addr==i, both writes still occur. The value is unchanged because min==temp. No special case.
- Swap is unconditional every outer iteration: exactly 2·(N-1) Mem_Write cycles per sort.
- Equal values: strict less-than, so the first occurrence stays min. Sort is not required to be stable.
- Latency: Done is high in cycle N(N-1)/2 + 3(N-1) + 1 after the edge that samples Start. Cycle 1 is the first LOAD_I. N=2 → 5, N=4 → 16, N=16 → 166.
- Start while Busy is ignored. Start held high through DONE starts a new sort on the first IDLE cycle.
- Rst mid-operation: immediate return to IDLE with reset outputs. No further writes. Memory is left partially sorted. The next Start sorts from scratch.
- Counters never wrap: LAST ≤ 255 is enforced at elaboration.

Test Plan:
- N=4, BASE=0, mem=[3,1,2,0], pulse Start → final mem=[0,1,2,3]; Done high in cycle 16 for exactly 1 cycle; 6 Mem_Write cycles; Busy high in cycles 1–16.
- N=4, mem already sorted [1,2,3,4] → mem unchanged; Done in cycle 16. Every SWAP2 has Sel_AMux=10 with min_addr==Cnt1.
- N=4, mem=[5,5,5,5] and mem=[FFFF,0000,FFFF,0000] → [5,5,5,5] and [0000,0000,FFFF,FFFF].
- N=16, BASE=8, mem[8..23]=15..0 descending → ascending 0..15 at 8..23; Done in cycle 166; no write outside 8..23.
- Start pulsed again at cycles 3 and 10 of a sort → ignored; single Done; result identical to the undisturbed run.
- Rst asserted during SCAN of the second outer iteration → all outputs return to reset values asynchronously; no Mem_Write afterward. A new Start then sorts fully; expected final contents checked.
